// File: rtl/riscv_proc_ctrl_wb_arb.sv
// riscv_proc_ctrl_wb_arb
//   Writeback arbiter and scoreboard sequencer for the long-latency units
//   (0 = mul/div, 1 = D-cache refill, 2 = FPU). Each unit drops a finished
//   result into a private one-entry buffer. The full buffers share regfile
//   write port 1 in round-robin order, and always give way to the main
//   pipeline. The block also drives both scoreboard ports: port 1 sets busy
//   on issue, and port 0 clears busy on writeback.
//
// Ports
//   clk, resetn                 core clock, async active-low reset
//   req_val/req_waddr/req_wdata per-requester result hand-off
//   req_rdy                     buffer i empty (registered only)
//   pipe_wb_val                 main pipeline owns the writeback slot
//   issue_val/issue_waddr       long-latency op issuing (set-busy)
//   rf_wen/rf_waddr/rf_wdata    regfile write port 1
//   sb_wen0/sb_waddr0/sb_wdata0 scoreboard clear port
//   sb_wen1/sb_waddr1/sb_wdata1 scoreboard set port
//   wb_stall_req                ask the pipeline for a writeback bubble
//   idle                        all buffers empty
module riscv_proc_ctrl_wb_arb #(
  parameter int NREQ       = 3,
  parameter int XLEN       = 64,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_val,
  input  logic [5*NREQ-1:0]    req_waddr,
  input  logic [XLEN*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]      req_rdy,
  input  logic                 pipe_wb_val,
  input  logic                 issue_val,
  input  logic [4:0]           issue_waddr,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 sb_wen0,
  output logic [4:0]           sb_waddr0,
  output logic                 sb_wdata0,
  output logic                 sb_wen1,
  output logic [4:0]           sb_waddr1,
  output logic                 sb_wdata1,
  output logic                 wb_stall_req,
  output logic                 idle
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [NREQ-1:0]           buf_full_q,  buf_full_d;
  logic [NREQ-1:0][4:0]      buf_waddr_q, buf_waddr_d;
  logic [NREQ-1:0][XLEN-1:0] buf_wdata_q, buf_wdata_d;
  logic [PW-1:0]             rr_ptr_q,    rr_ptr_d;
  logic [3:0]                starve_cnt_q, starve_cnt_d;

  logic          gnt_val;
  logic [PW-1:0] gnt_idx;

  // Round-robin pick among full buffers, starting at rr_ptr. The loop runs
  // from the farthest offset down to the nearest, so the nearest full
  // buffer is the last one assigned and therefore wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_val = 1'b0;
    gnt_idx = '0;
    if (!pipe_wb_val) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % NREQ;
        if (buf_full_q[idx]) begin
          gnt_val = 1'b1;
          gnt_idx = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    int nxt;
    nxt          = 0;
    buf_full_d   = buf_full_q;
    buf_waddr_d  = buf_waddr_q;
    buf_wdata_d  = buf_wdata_q;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = 4'd0;

    // A buffer is granted only while full and accepts only while empty, so
    // the clear and the load never hit the same entry in one cycle.
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_val && (int'(gnt_idx) == i)) begin
        buf_full_d[i] = 1'b0;
      end
      if (req_val[i] && !buf_full_q[i]) begin
        buf_full_d[i]  = 1'b1;
        buf_waddr_d[i] = req_waddr[5*i +: 5];
        buf_wdata_d[i] = req_wdata[XLEN*i +: XLEN];
      end
    end

    if (gnt_val) begin
      nxt = int'(gnt_idx) + 1;
      if (nxt >= NREQ) nxt = 0;
      rr_ptr_d = PW'(nxt);
    end

    if ((|buf_full_q) && pipe_wb_val) begin
      starve_cnt_d = (starve_cnt_q == LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_full_q   <= '0;
      buf_waddr_q  <= '0;
      buf_wdata_q  <= '0;
      rr_ptr_q     <= '0;
      starve_cnt_q <= 4'd0;
    end else begin
      buf_full_q   <= buf_full_d;
      buf_waddr_q  <= buf_waddr_d;
      buf_wdata_q  <= buf_wdata_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // A grant to x0 still uses the slot and frees the buffer; only the
  // regfile write itself is masked.
  assign rf_waddr  = buf_waddr_q[gnt_idx];
  assign rf_wdata  = buf_wdata_q[gnt_idx];
  assign rf_wen    = gnt_val && (rf_waddr != 5'd0);

  assign sb_wen0   = gnt_val;
  assign sb_waddr0 = buf_waddr_q[gnt_idx];
  assign sb_wdata0 = 1'b0;

  // The set port has priority in the scoreboard. If the same register is
  // cleared and set in one cycle it ends busy, because a new writer is in flight.
  assign sb_wen1   = issue_val;
  assign sb_waddr1 = issue_waddr;
  assign sb_wdata1 = 1'b1;

  assign req_rdy      = ~buf_full_q;
  assign idle         = ~|buf_full_q;
  assign wb_stall_req = (starve_cnt_q == LIM);

endmodule

// File: tb/tb_riscv_proc_ctrl_wb_arb.sv
module tb_riscv_proc_ctrl_wb_arb;

  localparam int NREQ = 3;
  localparam int XLEN = 64;

  logic                 clk;
  logic                 resetn;
  logic [NREQ-1:0]      req_val;
  logic [5*NREQ-1:0]    req_waddr;
  logic [XLEN*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]      req_rdy;
  logic                 pipe_wb_val;
  logic                 issue_val;
  logic [4:0]           issue_waddr;
  logic                 rf_wen;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 sb_wen0, sb_wdata0, sb_wen1, sb_wdata1;
  logic [4:0]           sb_waddr0, sb_waddr1;
  logic                 wb_stall_req;
  logic                 idle;

  int n_tot = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int wr_snap;
  logic [31:0] sb_bits = '0;

  riscv_proc_ctrl_wb_arb #(.NREQ(NREQ), .XLEN(XLEN), .STARVE_LIM(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_val(req_val), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_rdy(req_rdy), .pipe_wb_val(pipe_wb_val),
    .issue_val(issue_val), .issue_waddr(issue_waddr),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sb_wen0(sb_wen0), .sb_waddr0(sb_waddr0), .sb_wdata0(sb_wdata0),
    .sb_wen1(sb_wen1), .sb_waddr1(sb_waddr1), .sb_wdata1(sb_wdata1),
    .wb_stall_req(wb_stall_req), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard as the real one behaves: the set port overrides the clear port.
  always @(posedge clk) begin
    if (rf_wen) wr_cnt = wr_cnt + 1;
    if (sb_wen0) sb_bits[sb_waddr0] = 1'b0;
    if (sb_wen1) sb_bits[sb_waddr1] = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [4:0] a, input logic [63:0] d);
    req_val[i]             = 1'b1;
    req_waddr[5*i +: 5]    = a;
    req_wdata[XLEN*i +: XLEN] = d;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    req_val     = '0;
    pipe_wb_val = 1'b0;
    issue_val   = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    resetn      = 1'b0;
    req_val     = '0;
    req_waddr   = '0;
    req_wdata   = '0;
    pipe_wb_val = 1'b0;
    issue_val   = 1'b1;
    issue_waddr = 5'd9;
    #3;
    // Outputs while held in reset; the issue path still passes through.
    chk("rst_rdy",   64'(req_rdy), 64'h7);
    chk("rst_idle",  64'(idle), 64'h1);
    chk("rst_rfwen", 64'(rf_wen), 64'h0);
    chk("rst_sbw0",  64'(sb_wen0), 64'h0);
    chk("rst_stall", 64'(wb_stall_req), 64'h0);
    chk("rst_sbw1",  64'(sb_wen1), 64'h1);
    chk("rst_sba1",  64'(sb_waddr1), 64'd9);
    chk("const_d0",  64'(sb_wdata0), 64'h0);
    chk("const_d1",  64'(sb_wdata1), 64'h1);
    issue_val = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    sb_bits = '0;

    // A result accepted at edge 0 is written in the cycle that follows.
    load(0, 5'd5, 64'hAB);
    tick();
    req_val = '0;
    chk("a_rfwen",  64'(rf_wen), 64'h1);
    chk("a_rfaddr", 64'(rf_waddr), 64'd5);
    chk("a_rfdata", rf_wdata, 64'hAB);
    chk("a_sbw0",   64'(sb_wen0), 64'h1);
    chk("a_sba0",   64'(sb_waddr0), 64'd5);
    chk("a_rdy0",   64'(req_rdy[0]), 64'h0);
    chk("a_idle0",  64'(idle), 64'h0);
    tick();
    chk("a_idle1",  64'(idle), 64'h1);
    chk("a_rdy1",   64'(req_rdy), 64'h7);
    chk("a_rfwen1", 64'(rf_wen), 64'h0);

    // All three buffers loaded at once with rr_ptr = 0 -> order 1, 2, 3.
    do_reset();
    load(0, 5'd1, 64'h11);
    load(1, 5'd2, 64'h22);
    load(2, 5'd3, 64'h33);
    tick();
    req_val = '0;
    chk("rr0_g0", 64'(rf_waddr), 64'd1);
    chk("rr0_d0", rf_wdata, 64'h11);
    tick();
    chk("rr0_g1", 64'(rf_waddr), 64'd2);
    chk("rr0_rdy", 64'(req_rdy), 64'h1);
    tick();
    chk("rr0_g2", 64'(rf_waddr), 64'd3);
    chk("rr0_d2", rf_wdata, 64'h33);
    tick();
    chk("rr0_idle", 64'(idle), 64'h1);
    chk("rr0_nowen", 64'(sb_wen0), 64'h0);
    // rr_ptr is back at 0; a lone grant to buffer 1 moves it to 2.
    load(1, 5'd4, 64'h44);
    tick();
    req_val = '0;
    chk("rr_mv", 64'(rf_waddr), 64'd4);
    tick();
    load(0, 5'd1, 64'h11);
    load(1, 5'd2, 64'h22);
    load(2, 5'd3, 64'h33);
    tick();
    req_val = '0;
    chk("rr2_g0", 64'(rf_waddr), 64'd3);
    tick();
    chk("rr2_g1", 64'(rf_waddr), 64'd1);
    tick();
    chk("rr2_g2", 64'(rf_waddr), 64'd2);
    tick();
    chk("rr2_idle", 64'(idle), 64'h1);

    // Starvation: buffer 1 is held off by the pipeline. The stall request
    // rises on the 5th blocked cycle.
    pipe_wb_val = 1'b1;
    load(1, 5'd10, 64'hA0);
    tick();
    req_val = '0;
    chk("st_rfwen", 64'(rf_wen), 64'h0);
    chk("st_sbw0",  64'(sb_wen0), 64'h0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("st_low%0d", c), 64'(wb_stall_req), 64'h0);
      tick();
    end
    chk("st_high5", 64'(wb_stall_req), 64'h1);
    tick();
    chk("st_sat6", 64'(wb_stall_req), 64'h1);
    pipe_wb_val = 1'b0;
    #1;
    chk("st_gnt",  64'(rf_waddr), 64'd10);
    chk("st_wen",  64'(rf_wen), 64'h1);
    tick();
    chk("st_clr",  64'(wb_stall_req), 64'h0);
    chk("st_idle", 64'(idle), 64'h1);

    // Issue on register 7 sets it busy. The writeback to 7 then lands in the
    // same cycle as a new issue to 7, so the register must stay busy.
    issue_val   = 1'b1;
    issue_waddr = 5'd7;
    load(2, 5'd7, 64'h77);
    tick();
    req_val = '0;
    chk("cs_sbw0", 64'(sb_wen0), 64'h1);
    chk("cs_sba0", 64'(sb_waddr0), 64'd7);
    chk("cs_sbw1", 64'(sb_wen1), 64'h1);
    chk("cs_sba1", 64'(sb_waddr1), 64'd7);
    chk("cs_data", rf_wdata, 64'h77);
    tick();
    issue_val = 1'b0;
    chk("cs_busy", 64'(sb_bits[7]), 64'h1);

    // A write to x0 is masked, but the slot is still consumed.
    load(0, 5'd0, 64'h55);
    tick();
    req_val = '0;
    chk("x0_rfwen", 64'(rf_wen), 64'h0);
    chk("x0_sbw0",  64'(sb_wen0), 64'h1);
    chk("x0_sba0",  64'(sb_waddr0), 64'd0);
    tick();
    chk("x0_rdy",   64'(req_rdy[0]), 64'h1);
    chk("x0_idle",  64'(idle), 64'h1);

    // A reset while two buffers are full drops both results unwritten.
    pipe_wb_val = 1'b1;
    load(0, 5'd3, 64'h33);
    load(2, 5'd4, 64'h44);
    tick();
    req_val = '0;
    wr_snap = wr_cnt;
    chk("mr_full", 64'(req_rdy), 64'h2);
    resetn = 1'b0;
    #1;
    chk("mr_idle",  64'(idle), 64'h1);
    chk("mr_rdy",   64'(req_rdy), 64'h7);
    chk("mr_rfwen", 64'(rf_wen), 64'h0);
    pipe_wb_val = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    tick();
    chk("mr_nowr", 64'(wr_cnt - wr_snap), 64'h0);
    chk("mr_idle2", 64'(idle), 64'h1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
